// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order instruction queue decoupling fetch from decode
//   clk_i / rst_ni        clock, asynchronous active-low reset
//   flush_i               empty the queue and drop this cycle's push
//   fe_*                  fetch-side valid/ready handshake plus instruction payload
//   de_*                  decode-side head entry with valid/ready handshake
//   count_o               current occupancy, 0..DEPTH
module fetch_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       fe_valid_i,
    output logic                       fe_ready_o,
    input  logic [XLEN-1:0]            fe_pc_i,
    input  logic [XLEN-1:0]            fe_pc2_i,
    input  logic [XLEN-1:0]            fe_pc4_i,
    input  logic [XLEN-1:0]            fe_inst_i,
    input  logic                       fe_is_comp_i,
    input  logic                       fe_spec_taken_i,
    input  logic [XLEN-1:0]            fe_spec_pc_i,
    output logic                       de_valid_o,
    input  logic                       de_ready_i,
    output logic [XLEN-1:0]            de_pc_o,
    output logic [XLEN-1:0]            de_pc2_o,
    output logic [XLEN-1:0]            de_pc4_o,
    output logic [XLEN-1:0]            de_inst_o,
    output logic                       de_is_comp_o,
    output logic                       de_spec_taken_o,
    output logic [XLEN-1:0]            de_spec_pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc2;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            is_comp;
        logic            spec_taken;
        logic [XLEN-1:0] spec_pc;
    } entry_t;
    localparam entry_t IDLE = '{pc: '0, pc2: '0, pc4: '0, inst: NOP,
                                is_comp: 1'b0, spec_taken: 1'b0, spec_pc: '0};
    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;
    // ready depends only on occupancy, so a pop never enables a same-cycle refill when full
    assign fe_ready_o = cnt_q != CW'(DEPTH);
    assign de_valid_o = cnt_q != '0;
    assign push       = fe_valid_i & fe_ready_o & ~flush_i;
    assign pop        = de_valid_o & de_ready_i & ~flush_i;
    // power-of-two DEPTH lets the pointers wrap naturally
    always_comb begin
        rd_d  = flush_i ? '0 : rd_q + AW'(pop);
        wr_d  = flush_i ? '0 : wr_q + AW'(push);
        cnt_d = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    // payload storage needs no reset: empty slots are masked at the output
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= '{pc: fe_pc_i, pc2: fe_pc2_i, pc4: fe_pc4_i, inst: fe_inst_i,
                                   is_comp: fe_is_comp_i, spec_taken: fe_spec_taken_i,
                                   spec_pc: fe_spec_pc_i};
    end
    assign head            = de_valid_o ? mem_q[rd_q] : IDLE;
    assign de_pc_o         = head.pc;
    assign de_pc2_o        = head.pc2;
    assign de_pc4_o        = head.pc4;
    assign de_inst_o       = head.inst;
    assign de_is_comp_o    = head.is_comp;
    assign de_spec_taken_o = head.spec_taken;
    assign de_spec_pc_o    = head.spec_pc;
    assign count_o         = cnt_q;
endmodule
